// File: rtl/fifo_rd_pkg.sv
// Shared types and default sizing for the FIFO read-side controller.
package fifo_rd_pkg;

    localparam int unsigned DW_DEF        = 8;
    localparam int unsigned PTR_W_DEF     = 4;
    localparam int unsigned BUF_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } rd_state_e;

endpackage

// File: rtl/fifo_rd_ringbuf.sv
// Small ring buffer holding bytes popped from the FIFO until the consumer takes them.
// The writer guarantees push never hits a full buffer; pop on empty is ignored.
module fifo_rd_ringbuf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DW    = DW_DEF,
    parameter int unsigned DEPTH = BUF_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              din,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rp];

    // Storage, pointers and occupancy; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp      <= wp + AW'(1);
            end
            if (pop_ok) begin
                rp <= rp + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the synchronous FIFO: issues pops, captures the returning byte
// and presents it on a valid/ready stream. Optional statistics under FIFO_RD_STATS_EN.
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned PTR_W     = PTR_W_DEF,
    parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [PTR_W-1:0]               wrptr,
    input  logic [PTR_W-1:0]               rdptr,
    output logic                           rd,
    input  logic [DW-1:0]                  dout,
    output logic [DW-1:0]                  out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(BUF_DEPTH+1)-1:0] buf_cnt
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]                    pop_cnt,
    output logic [PTR_W-1:0]               max_level
`endif
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH+1);
    localparam int unsigned USE_W = CNT_W + 1;

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic              pend;
    logic              rd_next;
    logic [PTR_W-1:0]  level;
    logic [USE_W-1:0]  used;
    logic              has_avail;
    logic              has_credit;

    // An outstanding rd is not yet reflected in rdptr, so it reduces what is available.
    assign level      = wrptr - rdptr;
    assign has_avail  = level > PTR_W'(rd);
    // Slots already committed: buffered bytes plus the two pop stages in flight.
    assign used       = USE_W'(buf_cnt) + USE_W'(rd) + USE_W'(pend);
    assign has_credit = used < USE_W'(BUF_DEPTH);

    // Next-state and pop decision.
    always_comb begin
        state_nxt = state;
        rd_next   = 1'b0;
        rd_next   = en && has_avail && has_credit;
        case (state)
            IDLE: begin
                if (en && has_avail) begin
                    state_nxt = has_credit ? RUN : STALL;
                end
            end
            RUN: begin
                if (!(en && has_avail)) begin
                    state_nxt = IDLE;
                end else if (!has_credit) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                if (!(en && has_avail)) begin
                    state_nxt = IDLE;
                end else if (has_credit) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pop strobe and the capture flag that tracks the FIFO read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rd    <= 1'b0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd    <= rd_next;
            pend  <= rd;
        end
    end

    fifo_rd_ringbuf #(
        .DW    (DW),
        .DEPTH (BUF_DEPTH)
    ) u_ringbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (pend),
        .din   (dout),
        .pop   (out_ready),
        .head  (out_data),
        .count (buf_cnt)
    );

    assign out_valid = (buf_cnt != '0);

`ifdef FIFO_RD_STATS_EN
    // Accepted-byte counter and high-water mark of the FIFO level.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_cnt   <= '0;
            max_level <= '0;
        end else begin
            if (out_valid && out_ready) begin
                pop_cnt <= pop_cnt + 16'd1;
            end
            if (level > max_level) begin
                max_level <= level;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural FIFO plus queue-based reference of delivered bytes.
module tb_fifo_rd_ctrl;
    import fifo_rd_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] wrptr = 4'h0;
    logic [3:0] rdptr = 4'h0;
    logic       rd;
    logic [7:0] dout = 8'h00;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] buf_cnt;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] pop_cnt;
    logic [3:0]  max_level;
    int unsigned pop_m = 0;
    logic [3:0]  max_m = 4'h0;
`endif

    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ld = 1'b0;
    logic [3:0] ld_ptr = 4'h0;
    logic [7:0] mem [8];
    logic [7:0] fifo_q [$];
    logic [7:0] out_q [$];
    int         pend_m = 0;
    int         rd_cnt = 0;
    int         xfer_cnt = 0;
    bit         mon_on = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    fifo_rd_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .wrptr     (wrptr),
        .rdptr     (rdptr),
        .rd        (rd),
        .dout      (dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .buf_cnt   (buf_cnt)
`ifdef FIFO_RD_STATS_EN
        ,
        .pop_cnt   (pop_cnt),
        .max_level (max_level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] level_now();
        return wrptr - rdptr;
    endfunction

    // Behavioural FIFO and reference model, evaluated on the same edge the DUT samples.
    always @(posedge clk) begin
        logic [7:0] b;
        logic       xfer;
        xfer = out_valid && out_ready;
`ifdef FIFO_RD_STATS_EN
        if (rst) begin
            pop_m = 0;
            max_m = 4'h0;
        end else begin
            if (xfer) pop_m = (pop_m + 1) % 65536;
            if (level_now() > max_m) max_m = level_now();
        end
`endif
        if (ld) begin
            wrptr <= ld_ptr;
            rdptr <= ld_ptr;
        end else begin
            if (wr_req && fifo_q.size() < 8) begin
                mem[wrptr[2:0]] <= wr_data;
                fifo_q.push_back(wr_data);
                wrptr <= wrptr + 4'd1;
            end
            if (rd) begin
                dout  <= mem[rdptr[2:0]];
                rdptr <= rdptr + 4'd1;
                rd_cnt++;
                if (fifo_q.size() > 0) begin
                    b = fifo_q.pop_front();
                    if (!rst) out_q.push_back(b);
                end
            end
        end
        if (rst) begin
            out_q.delete();
        end else if (xfer && out_q.size() > 0) begin
            void'(out_q.pop_front());
            xfer_cnt++;
        end
        pend_m = (rd && !rst) ? 1 : 0;
    end

    // Continuous comparison of the stream against the reference.
    always @(negedge clk) begin
        int exp_cnt;
        if (mon_on) begin
            exp_cnt = out_q.size() - pend_m;
            check_eq("buf_cnt", 32'(buf_cnt), 32'(exp_cnt));
            check_eq("out_valid", 32'(out_valid), 32'(exp_cnt != 0));
            if (out_valid && exp_cnt > 0) check_eq("out_data", 32'(out_data), 32'(out_q[0]));
            if (rd) check_eq("rd_nonempty", 32'(level_now() != 4'h0), 32'd1);
`ifdef FIFO_RD_STATS_EN
            check_eq("pop_cnt", 32'(pop_cnt), 32'(pop_m));
            check_eq("max_level", 32'(max_level), 32'(max_m));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] v);
        wr_data = v;
        wr_req  = 1'b1;
        cyc(1);
        wr_req  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        check_eq("rst_rd", 32'(rd), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_buf_cnt", 32'(buf_cnt), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        logic       rd_h [16];
        logic       ov_h [16];
        logic [7:0] od_h [16];
        int r0;
        int x0;
        bit found;

        cyc(1);
        do_reset();
        mon_on = 1'b1;

        // Empty FIFO: no pops at all.
        en = 1'b1;
        r0 = rd_cnt;
        cyc(20);
        check_eq("t1_no_rd", 32'(rd_cnt - r0), 32'd0);
        check_eq("t1_no_valid", 32'(out_valid), 32'd0);

        // Three bytes, back-to-back pops and 2-cycle latency.
        en = 1'b0;
        write_byte(8'hA1);
        write_byte(8'hB2);
        write_byte(8'hC3);
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            rd_h[i] = rd;
            ov_h[i] = out_valid;
            od_h[i] = out_data;
        end
        check_eq("t2_rd1", 32'(rd_h[1]), 32'd1);
        check_eq("t2_rd2", 32'(rd_h[2]), 32'd1);
        check_eq("t2_rd3", 32'(rd_h[3]), 32'd1);
        for (int i = 4; i <= 10; i++) check_eq("t2_no_4th_rd", 32'(rd_h[i]), 32'd0);
        check_eq("t2_ov2", 32'(ov_h[2]), 32'd0);
        check_eq("t2_ov3", 32'(ov_h[3]), 32'd1);
        check_eq("t2_d3", 32'(od_h[3]), 32'hA1);
        check_eq("t2_d4", 32'(od_h[4]), 32'hB2);
        check_eq("t2_d5", 32'(od_h[5]), 32'hC3);
        check_eq("t2_ov6", 32'(ov_h[6]), 32'd0);
        check_eq("t2_level", 32'(level_now()), 32'd0);

        // Full FIFO with a stalled consumer: buffer fills, controller stalls.
        en = 1'b0;
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) write_byte(8'(8'h10 + i));
        check_eq("t3_level", 32'(level_now()), 32'd8);
        r0 = rd_cnt;
        en = 1'b1;
        cyc(12);
        check_eq("t3_rd_pulses", 32'(rd_cnt - r0), 32'd4);
        check_eq("t3_buf_full", 32'(buf_cnt), 32'd4);
        check_eq("t3_stall", 32'(dut.state), 32'(STALL));
        x0 = xfer_cnt;
        out_ready = 1'b1;
        cyc(20);
        check_eq("t3_xfers", 32'(xfer_cnt - x0), 32'd8);
        check_eq("t3_drained", 32'(level_now()), 32'd0);

        // Pointer wrap through the MSB.
        en = 1'b0;
        ld_ptr = 4'hE;
        ld = 1'b1;
        cyc(1);
        ld = 1'b0;
        for (int i = 0; i < 4; i++) write_byte(8'(8'h50 + i));
        check_eq("t4_level", 32'(level_now()), 32'd4);
        r0 = rd_cnt;
        x0 = xfer_cnt;
        en = 1'b1;
        cyc(15);
        check_eq("t4_rdptr", 32'(rdptr), 32'h2);
        check_eq("t4_rd_pulses", 32'(rd_cnt - r0), 32'd4);
        check_eq("t4_xfers", 32'(xfer_cnt - x0), 32'd4);

        // Drop en in the cycle rd is high.
        en = 1'b0;
        for (int i = 0; i < 4; i++) write_byte(8'(8'h60 + i));
        r0 = rd_cnt;
        x0 = xfer_cnt;
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc(1);
            if (rd) found = 1'b1;
        end
        check_eq("t5_rd_seen", 32'(found), 32'd1);
        en = 1'b0;
        cyc(8);
        check_eq("t5_one_rd", 32'(rd_cnt - r0), 32'd1);
        check_eq("t5_one_xfer", 32'(xfer_cnt - x0), 32'd1);
        check_eq("t5_level", 32'(level_now()), 32'd3);
        en = 1'b1;
        cyc(12);
        check_eq("t5_resume", 32'(xfer_cnt - x0), 32'd4);
        check_eq("t5_level_end", 32'(level_now()), 32'd0);

        // Reset with three buffered bytes and one in flight.
        en = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) write_byte(8'(8'h70 + i));
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1);
            if (buf_cnt == 3'd3 && pend_m == 1) found = 1'b1;
        end
        check_eq("t6_setup", 32'(found), 32'd1);
        rst = 1'b1;
        cyc(1);
        check_eq("t6_rd", 32'(rd), 32'd0);
        check_eq("t6_out_valid", 32'(out_valid), 32'd0);
        check_eq("t6_out_data", 32'(out_data), 32'd0);
        check_eq("t6_buf_cnt", 32'(buf_cnt), 32'd0);
`ifdef FIFO_RD_STATS_EN
        check_eq("t6_pop_cnt", 32'(pop_cnt), 32'd0);
        check_eq("t6_max_level", 32'(max_level), 32'd0);
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        cyc(20);
        check_eq("t6_drained", 32'(level_now()), 32'd0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            wr_req    = 1'($urandom_range(0, 1));
            wr_data   = 8'($urandom);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        wr_req = 1'b0;
        rst = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        cyc(40);
        check_eq("rand_fifo_empty", 32'(level_now()), 32'd0);
        check_eq("rand_out_empty", 32'(out_q.size()), 32'd0);
        check_eq("rand_buf_cnt", 32'(buf_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
